win3x3_stream_gen: RTL and testbench

- Parametrised successor to the fixed 258x258 frame-memory window generator.
- Streams a pre-padded image in raster order through a valid/ready input.
- Keeps two line buffers plus a 3x3 register window, so the full frame is never stored.
- Emits one 3x3 neighbourhood per interior pixel on a valid/ready output, feeding the edge-preserving filter core.

---
 rtl/win_pkg.sv | 29 ++
 rtl/win3x3_stream_gen_if.sv | 28 ++
 rtl/line_buffer.sv | 25 ++
 rtl/win3x3_stream_gen.sv | 157 +++++++++++++++
 tb/tb_win3x3_stream_gen.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared constants, state encoding and window helper for win3x3_stream_gen
// Purpose: default pixel width, window tap indices (row-major, w0 = top-left),
//          FSM state encoding and a helper that extracts one tap from a packed window.
// Ports:   none (package).
package win_pkg;

    localparam int PIX_W_DEF = 8;

    localparam int W_TL = 0;
    localparam int W_TC = 1;
    localparam int W_TR = 2;
    localparam int W_ML = 3;
    localparam int W_MC = 4;
    localparam int W_MR = 5;
    localparam int W_BL = 6;
    localparam int W_BC = 7;
    localparam int W_BR = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic [PIX_W_DEF-1:0] win_pix(input logic [9*PIX_W_DEF-1:0] win, input int k);
        return win[k*PIX_W_DEF +: PIX_W_DEF];
    endfunction

endpackage

// File: rtl/win3x3_stream_gen_if.sv
// rtl/win3x3_stream_gen_if.sv - pixel input and window output handshake bundle
// Purpose: groups the pixel stream (in_*) and the window stream (out_*).
// Ports:   in_valid/in_ready/in_pixel  pixel stream into the generator
//          out_valid/out_ready/out_win/out_row/out_col  window stream out
// Modports: slave = generator side, master = source/sink side.
interface win3x3_stream_gen_if #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [PIX_W-1:0]   in_pixel;
    logic               out_valid;
    logic               out_ready;
    logic [9*PIX_W-1:0] out_win;
    logic [CNT_W-1:0]   out_row;
    logic [CNT_W-1:0]   out_col;

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_win, out_row, out_col
    );

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_win, out_row, out_col
    );
endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one image line of pixel storage
// Purpose: DEPTH x W memory, synchronous write, asynchronous read, shared address.
// Ports:   clk, we (write enable), addr, wdata, rdata (combinational read of addr).
module line_buffer #(
    parameter int DEPTH = 258,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read-before-write: the old value at addr is seen in the same cycle it is overwritten.
    assign rdata = mem[addr];
endmodule

// File: rtl/win3x3_stream_gen.sv
// rtl/win3x3_stream_gen.sv - streaming 3x3 neighbourhood generator for a pre-padded frame
// Purpose: takes a padded frame in raster order and emits one 3x3 window per interior
//          pixel using two line buffers and a 3x3 register window.
// Ports:   clk, rst (sync, active-high), start (arms a frame in IDLE),
//          s (win3x3_stream_gen_if.slave: pixel in, window out with centre row/col),
//          busy (not IDLE), done (pulse when last window is consumed),
//          stall_cnt (only with WIN3X3_STALL_CNT_EN: out_valid && !out_ready cycles this frame).
// Config:  WIN3X3_STALL_CNT_EN
module win3x3_stream_gen
    import win_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int IMG_W = 258,
    parameter int IMG_H = 258,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    win3x3_stream_gen_if.slave  s,
    output logic                busy,
    output logic                done
`ifdef WIN3X3_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);
    localparam int              AW     = $clog2(IMG_W);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_R = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   row, col;
    logic [PIX_W-1:0]   win     [9];
    logic [PIX_W-1:0]   win_nxt [9];
    logic [9*PIX_W-1:0] win_flat;
    logic [PIX_W-1:0]   lb0_rd, lb1_rd;
    logic               out_free, accept, last_pix, produce, arm;

    // Single output register, no skid: input stalls whenever a held window is not taken.
    assign out_free   = !s.out_valid || s.out_ready;
    assign s.in_ready = (state == ST_RUN) && out_free;
    assign accept     = s.in_valid && s.in_ready;
    assign last_pix   = (row == LAST_R) && (col == LAST_C);
    // c>=2 also masks the stale columns that wrapped in from the previous row.
    assign produce    = accept && (row >= TWO) && (col >= TWO);
    assign arm        = (state == ST_IDLE) && start;
    assign busy       = (state != ST_IDLE);

    line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col[AW-1:0]),
        .wdata (s.in_pixel),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col[AW-1:0]),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (accept && last_pix) state_nxt = ST_FLUSH;
            ST_FLUSH: begin
                if (out_free) begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Shift left by one column; the new right column is {lb1[c], lb0[c], p} top to bottom.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            win_nxt[3*k]     = win[3*k+1];
            win_nxt[3*k + 1] = win[3*k+2];
            win_nxt[3*k + 2] = win[3*k+2];
        end
        win_nxt[W_TR] = lb1_rd;
        win_nxt[W_MR] = lb0_rd;
        win_nxt[W_BR] = s.in_pixel;
        win_flat = '0;
        for (int k = 0; k < 9; k++) begin
            win_flat[k*PIX_W +: PIX_W] = win_nxt[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row         <= '0;
            col         <= '0;
            s.out_valid <= 1'b0;
            s.out_win   <= '0;
            s.out_row   <= '0;
            s.out_col   <= '0;
            for (int k = 0; k < 9; k++) begin
                win[k] <= '0;
            end
        end else begin
            if (arm) begin
                row <= '0;
                col <= '0;
            end else if (accept) begin
                if (col == LAST_C) begin
                    col <= '0;
                    row <= row + ONE;
                end else begin
                    col <= col + ONE;
                end
            end
            if (accept) begin
                for (int k = 0; k < 9; k++) begin
                    win[k] <= win_nxt[k];
                end
            end
            if (produce) begin
                s.out_valid <= 1'b1;
                s.out_win   <= win_flat;
                s.out_row   <= row - ONE;
                s.out_col   <= col - ONE;
            end else if (s.out_ready) begin
                s.out_valid <= 1'b0;
            end
        end
    end

`ifdef WIN3X3_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            stall_cnt <= '0;
        end else if (s.out_valid && !s.out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_win3x3_stream_gen.sv
// tb/tb_win3x3_stream_gen.sv - scoreboard bench for win3x3_stream_gen
module tb_win3x3_stream_gen;
    import win_pkg::*;

    localparam int PW = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done;
    logic start_b = 1'b0;
    logic busy_b, done_b;
`ifdef WIN3X3_STALL_CNT_EN
    logic [31:0] stall_cnt, stall_cnt_b;
`endif

    win3x3_stream_gen_if #(.PIX_W(PW), .CNT_W(CW)) sif ();
    win3x3_stream_gen_if #(.PIX_W(PW), .CNT_W(CW)) bif ();

    win3x3_stream_gen #(.PIX_W(PW), .IMG_W(4), .IMG_H(4), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .s     (sif),
        .busy  (busy),
        .done  (done)
`ifdef WIN3X3_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    win3x3_stream_gen #(.PIX_W(PW), .IMG_W(258), .IMG_H(258), .CNT_W(CW)) dut_big (
        .clk   (clk),
        .rst   (rst),
        .start (start_b),
        .s     (bif),
        .busy  (busy_b),
        .done  (done_b)
`ifdef WIN3X3_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt_b)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [71:0] win;
        int          row;
        int          col;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    int exp_pix [4][9] = '{'{0, 1, 2, 4, 5, 6, 8, 9, 10},
                           '{1, 2, 3, 5, 6, 7, 9, 10, 11},
                           '{4, 5, 6, 8, 9, 10, 12, 13, 14},
                           '{5, 6, 7, 9, 10, 11, 13, 14, 15}};
    int exp_row [4] = '{1, 1, 2, 2};
    int exp_col [4] = '{1, 2, 1, 2};
    int exp_idx [4] = '{10, 11, 14, 15};

    function automatic logic [71:0] pack_win(input int n);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(exp_pix[n][k]);
        return w;
    endfunction

    task automatic chk_w(input string name, input logic [71:0] act, input logic [71:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, expv);
        end
    endtask

    // Output monitor: every presented window is compared against the scoreboard head.
    bit presented = 1'b0;
    int win_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst && sif.out_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_window: got window at row %0d col %0d, required none",
                         sif.out_row, sif.out_col);
            end else begin
                chk_w("win", sif.out_win, q[0].win);
                chk_i("row", int'(sif.out_row), q[0].row);
                chk_i("col", int'(sif.out_col), q[0].col);
                if (!presented) begin
                    chk_i("latency", cyc, q[0].acc + 1);
                    chk_i("centre", int'(win_pix(sif.out_win, W_MC)), int'(win_pix(q[0].win, W_MC)));
                    presented = 1'b1;
                end
                if (!sif.out_ready) begin
                    chk_i("in_ready_stall", int'(sif.in_ready), 0);
                end else begin
                    void'(q.pop_front());
                    presented = 1'b0;
                    win_cnt++;
                end
            end
        end
    end

    // Sink readiness: 0 = always ready, 1 = toggle, 2 = ready except forced holds.
    int rdy_mode = 0;
    int hold_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (hold_cnt > 0) begin
            sif.out_ready = 1'b0;
            hold_cnt--;
        end else if (rdy_mode == 1) begin
            sif.out_ready = !sif.out_ready;
        end else begin
            sif.out_ready = 1'b1;
        end
    end

    int big_cnt = 0;
    int big_last_r = 0;
    int big_last_c = 0;
    always @(negedge clk) begin
        if (!rst && bif.out_valid && bif.out_ready) begin
            big_cnt++;
            big_last_r = int'(bif.out_row);
            big_last_c = int'(bif.out_col);
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk_i("busy_after_start", int'(busy), 1);
    endtask

    task automatic send_frame(input bit gaps, input int abort_after, input bit start_mid);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < 16 && guard < 500) begin
            @(posedge clk); #1;
            sif.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            sif.in_pixel = 8'(idx);
            start = start_mid && (idx == 5);
            @(negedge clk);
            guard++;
            if (sif.in_valid && sif.in_ready) begin
                for (int n = 0; n < 4; n++) begin
                    if (exp_idx[n] == idx) q.push_back('{pack_win(n), exp_row[n], exp_col[n], cyc});
                end
                if (idx == 11 && rdy_mode != 0) hold_cnt = 5;
                idx++;
                if (idx == abort_after) break;
            end
        end
        if (guard >= 500) chk_i("send_timeout", guard, 0);
        @(posedge clk); #1;
        sif.in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic finish_frame(input int win0, input int done0);
        int g;
        g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk_i("frame_timeout", int'(g < 200), 1);
        repeat (3) @(negedge clk);
        chk_i("windows", win_cnt - win0, 4);
        chk_i("done_once", done_cnt - done0, 1);
        chk_i("busy_end", int'(busy), 0);
        chk_i("queue_empty", q.size(), 0);
    endtask

    task automatic full_frame(input bit gaps, input bit start_mid);
        int w0;
        int d0;
        w0 = win_cnt;
        d0 = done_cnt;
        do_start();
        send_frame(gaps, 0, start_mid);
        finish_frame(w0, d0);
    endtask

    initial begin
        int w0;
        int d0;
        int g;
        sif.in_valid = 1'b0;
        sif.in_pixel = '0;
        sif.out_ready = 1'b1;
        bif.in_valid = 1'b1;
        bif.in_pixel = 8'h5a;
        bif.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_i("rst_in_ready", int'(sif.in_ready), 0);
        chk_i("rst_out_valid", int'(sif.out_valid), 0);
        chk_w("rst_out_win", sif.out_win, 72'd0);
        chk_i("rst_out_row", int'(sif.out_row), 0);
        chk_i("rst_out_col", int'(sif.out_col), 0);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_done", int'(done), 0);
        @(posedge clk); #1 rst = 1'b0;

        // fill
        full_frame(1'b0, 1'b0);

        // backpressure
        rdy_mode = 1;
        full_frame(1'b0, 1'b0);
        rdy_mode = 0;
        repeat (8) @(posedge clk);

        // input gaps
        full_frame(1'b1, 1'b0);

        // reset mid-frame
        d0 = done_cnt;
        do_start();
        send_frame(1'b0, 7, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_i("abort_in_ready", int'(sif.in_ready), 0);
        chk_i("abort_out_valid", int'(sif.out_valid), 0);
        chk_w("abort_out_win", sif.out_win, 72'd0);
        chk_i("abort_out_row", int'(sif.out_row), 0);
        chk_i("abort_out_col", int'(sif.out_col), 0);
        chk_i("abort_busy", int'(busy), 0);
        chk_i("abort_done", int'(done), 0);
        repeat (3) @(negedge clk);
        chk_i("abort_no_done", done_cnt - d0, 0);
        q.delete();
        full_frame(1'b0, 1'b0);

        // start during RUN
        full_frame(1'b0, 1'b1);

        // in_valid while IDLE
        w0 = win_cnt;
        @(posedge clk); #1 sif.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_i("idle_in_ready", int'(sif.in_ready), 0);
        end
        @(posedge clk); #1 sif.in_valid = 1'b0;
        @(negedge clk);
        chk_i("idle_busy", int'(busy), 0);
        chk_i("idle_no_windows", win_cnt - w0, 0);

`ifdef WIN3X3_STALL_CNT_EN
        rdy_mode = 2;
        full_frame(1'b0, 1'b0);
        rdy_mode = 0;
        chk_i("stall_cnt_after_done", int'(stall_cnt), 5);
        do_start();
        chk_i("stall_cnt_after_start", int'(stall_cnt), 0);
        send_frame(1'b0, 0, 1'b0);
        finish_frame(win_cnt - 4, done_cnt - 1);
`endif

        // full 258x258 frame
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        g = 0;
        while (!done_b && g < 70000) begin
            @(negedge clk);
            g++;
        end
        chk_i("big_timeout", int'(g < 70000), 1);
        @(negedge clk);
        chk_i("big_windows", big_cnt, 65536);
        chk_i("big_last_row", big_last_r, 256);
        chk_i("big_last_col", big_last_c, 256);
        chk_i("big_busy_end", int'(busy_b), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1500000;
        fails++;
        $display("FAIL watchdog: got timeout, required finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
